// File: rtl/mux_scan_pkg.sv
// Shared widths and state encoding for the mux scan controller.
package mux_scan_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/four_to_one.sv
// 4:1 single-bit multiplexer; {s1,s0} selects the input.
module four_to_one (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  assign y = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);

endmodule

// File: rtl/next_ch_sel.sv
// Channel walker: next enabled index above cur, last-channel flag and lowest
// enabled index of mask.
module next_ch_sel
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur,
  output logic [SELW-1:0] nxt,
  output logic            last,
  output logic [SELW-1:0] lowest
);

  // Descending scans so the final match is the smallest qualifying index.
  always_comb begin
    nxt    = cur;
    last   = 1'b1;
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = SELW'(i);
      end
      if (mask[i] && (i > int'(cur))) begin
        nxt  = SELW'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: dwells on each enabled channel, shadows the
// sampled bits and hands out one frame per scan over valid/ready.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cont,
  input  logic [NCH-1:0] ch_en,
  output logic           s1,
  output logic           s0,
  input  logic           y_in,
  output logic [NCH-1:0] frame,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic           busy
);

  localparam logic [CNTW-1:0] DwellLast = CNTW'(DWELL - 1);

  scan_state_e     state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]  shadow_q, shadow_d;
  logic [NCH-1:0]  en_q, en_d;
  logic [NCH-1:0]  frame_q, frame_d;
  logic            valid_q, valid_d;

  logic [NCH-1:0]  sampled, load_src;
  logic            slot_free, load, begin_scan;
  logic [SELW-1:0] next_sel, first_sel, unused_low, unused_next;
  logic            last_ch, unused_last;

  next_ch_sel u_scan_sel (
    .mask   (en_q),
    .cur    (sel_q),
    .nxt    (next_sel),
    .last   (last_ch),
    .lowest (unused_low)
  );

  next_ch_sel u_first_sel (
    .mask   (ch_en),
    .cur    (SELW'(0)),
    .nxt    (unused_next),
    .last   (unused_last),
    .lowest (first_sel)
  );

  assign slot_free = !valid_q || frame_ready;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    en_d     = en_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    load     = 1'b0;
    load_src = shadow_q;

    // Shadow with the current channel's bit replaced by the live mux output.
    sampled        = shadow_q;
    sampled[sel_q] = y_in;

    if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        cnt_d = '0;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DwellLast) begin
          shadow_d = sampled;
          cnt_d    = '0;
          if (!last_ch) begin
            sel_d = next_sel;
          end else if (slot_free) begin
            load     = 1'b1;
            load_src = sampled;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      frame_d = load_src & en_q;
      valid_d = 1'b1;
      state_d = ST_IDLE;
      sel_d   = '0;
      cnt_d   = '0;
    end

    begin_scan = (ch_en != '0) &&
                 (((state_q == ST_IDLE) && start) || (load && cont));
    if (begin_scan) begin
      en_d     = ch_en;
      shadow_d = '0;
      sel_d    = first_sel;
      cnt_d    = '0;
      state_d  = ST_SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      en_q     <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
    end
  end

  assign s1          = sel_q[1];
  assign s0          = sel_q[0];
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl driving a four_to_one mux; expectations come from a
// select-plan model built from the channel mask and the dwell time.
module tb_mux_scan_ctrl;

  localparam int unsigned DWELL = 2;

  logic       clk = 1'b0;
  logic       rst, start, cont, frame_ready, y;
  logic [3:0] ch_en, inp, frame;
  logic       s1, s0, frame_valid, busy;

  int checks = 0;
  int errors = 0;
  int plan[$];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .ch_en       (ch_en),
    .s1          (s1),
    .s0          (s0),
    .y_in        (y),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy)
  );

  four_to_one u_mux (
    .i0 (inp[0]),
    .i1 (inp[1]),
    .i2 (inp[2]),
    .i3 (inp[3]),
    .s1 (s1),
    .s0 (s0),
    .y  (y)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected select per cycle: each enabled channel, ascending, DWELL times.
  task automatic build_plan(input logic [3:0] m);
    plan.delete();
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int d = 0; d < int'(DWELL); d++) plan.push_back(ch);
      end
    end
  endtask

  // Single scan, always-ready consumer; inputs held constant for the scan.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] v);
    cont        = 1'b0;
    frame_ready = 1'b1;
    ch_en       = m;
    inp         = v;
    start       = 1'b1;
    step();
    start = 1'b0;
    ch_en = 4'($urandom);
    build_plan(m);
    for (int i = 0; i < plan.size(); i++) begin
      chk("scan_sel", {2'b00, s1, s0}, 4'(plan[i]));
      chk("scan_busy", {3'b000, busy}, 4'd1);
      chk("scan_valid_low", {3'b000, frame_valid}, 4'd0);
      step();
    end
    chk("scan_valid", {3'b000, frame_valid}, 4'd1);
    chk("scan_frame", frame, v & m);
    chk("scan_idle", {3'b000, busy}, 4'd0);
    chk("scan_sel_idle", {2'b00, s1, s0}, 4'd0);
    step();
    chk("scan_accept", {3'b000, frame_valid}, 4'd0);
  endtask

  initial begin
    logic [3:0] m, v, a, b, exp_frame;
    int kd;

    rst         = 1'b1;
    start       = 1'b0;
    cont        = 1'b0;
    ch_en       = '0;
    inp         = '0;
    frame_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_sel", {2'b00, s1, s0}, 4'd0);
    chk("rst_frame", frame, 4'd0);
    chk("rst_valid", {3'b000, frame_valid}, 4'd0);
    chk("rst_busy", {3'b000, busy}, 4'd0);

    // All channels, then a sparse mask with all-ones inputs.
    run_scan(4'hF, 4'b1010);
    run_scan(4'b0101, 4'hF);

    // Random single scans.
    for (int n = 0; n < 8; n++) begin
      m = 4'($urandom_range(1, 15));
      v = 4'($urandom);
      run_scan(m, v);
    end

    // Continuous mode with a stalled consumer: second scan parks in HOLD.
    a           = 4'($urandom);
    b           = ~a;
    cont        = 1'b1;
    frame_ready = 1'b0;
    ch_en       = 4'hF;
    inp         = a;
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4 * int'(DWELL); i++) step();
    chk("hold_first_valid", {3'b000, frame_valid}, 4'd1);
    chk("hold_first_frame", frame, a);
    inp = b;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("hold_stable_frame", frame, a);
      chk("hold_stable_valid", {3'b000, frame_valid}, 4'd1);
      if (c >= 4 * int'(DWELL)) begin
        chk("hold_sel", {2'b00, s1, s0}, 4'd3);
        chk("hold_busy", {3'b000, busy}, 4'd1);
      end
    end
    frame_ready = 1'b1;
    cont        = 1'b0;
    step();
    chk("hold_second_valid", {3'b000, frame_valid}, 4'd1);
    chk("hold_second_frame", frame, b);
    chk("hold_idle", {3'b000, busy}, 4'd0);
    step();
    chk("hold_accept", {3'b000, frame_valid}, 4'd0);

    // Continuous, always ready: back-to-back frames, cont dropped mid third scan.
    m           = 4'($urandom_range(1, 15));
    v           = 4'($urandom);
    cont        = 1'b1;
    frame_ready = 1'b1;
    ch_en       = m;
    inp         = v;
    start       = 1'b1;
    step();
    start = 1'b0;
    build_plan(m);
    kd        = plan.size();
    exp_frame = '0;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < kd; i++) begin
        chk("cont_sel", {2'b00, s1, s0}, 4'(plan[i]));
        chk("cont_busy", {3'b000, busy}, 4'd1);
        if (i == 0 && s > 0) begin
          chk("cont_valid", {3'b000, frame_valid}, 4'd1);
          chk("cont_frame", frame, exp_frame);
        end else begin
          chk("cont_valid_low", {3'b000, frame_valid}, 4'd0);
        end
        if (s == 2 && i == 1) cont = 1'b0;
        step();
      end
      exp_frame = v & m;
      if (s < 2) begin
        v   = 4'($urandom);
        inp = v;
      end
    end
    chk("cont_last_valid", {3'b000, frame_valid}, 4'd1);
    chk("cont_last_frame", frame, exp_frame);
    chk("cont_idle", {3'b000, busy}, 4'd0);
    step();
    chk("cont_accept", {3'b000, frame_valid}, 4'd0);

    // Reset while the third channel is selected.
    cont        = 1'b0;
    frame_ready = 1'b1;
    ch_en       = 4'hF;
    inp         = 4'($urandom);
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2 * int'(DWELL); i++) step();
    chk("midrst_sel_before", {2'b00, s1, s0}, 4'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sel", {2'b00, s1, s0}, 4'd0);
    chk("midrst_frame", frame, 4'd0);
    chk("midrst_valid", {3'b000, frame_valid}, 4'd0);
    chk("midrst_busy", {3'b000, busy}, 4'd0);
    run_scan(4'hF, 4'($urandom));

    // Start with an empty mask is ignored.
    ch_en = 4'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_busy", {3'b000, busy}, 4'd0);
    chk("empty_sel", {2'b00, s1, s0}, 4'd0);
    chk("empty_valid", {3'b000, frame_valid}, 4'd0);
    step();
    chk("empty_busy2", {3'b000, busy}, 4'd0);

    // Start while busy is ignored; only the original mask's frame appears.
    v     = 4'($urandom);
    inp   = v;
    ch_en = 4'b0011;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    ch_en = 4'hF;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 3; i < 2 * int'(DWELL); i++) step();
    step();
    chk("busystart_valid", {3'b000, frame_valid}, 4'd1);
    chk("busystart_frame", frame, v & 4'b0011);
    chk("busystart_idle", {3'b000, busy}, 4'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("busystart_no_extra", {3'b000, frame_valid}, 4'd0);
      chk("busystart_still_idle", {3'b000, busy}, 4'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
